// File: rtl/hazard_ctrl.sv
// hazard_ctrl - pipeline hazard controller for the 5-stage RV64 core.
//
// It detects load-use hazards, taken branches and data-memory wait. From
// these it drives the PC enable, the IF/ID write and flush controls, the
// ID/EX bubble and a global freeze. A small FSM with a down-counter
// sequences multi-cycle stalls and flushes, so no hazard is detected twice.
// All outputs are Mealy: they come from the current state and the inputs
// of the current cycle.
//
// Ports:
//   clk, reset         clock; asynchronous, active-high reset
//   i_id_rs1/rs2       source registers of the instruction in ID
//   i_id_uses_rs1/rs2  the ID instruction reads rs1/rs2
//   i_idex_mem_read    the instruction in ID/EX is a load
//   i_idex_rd          destination register of the instruction in ID/EX
//   i_ex_branch_taken  a branch or jump resolved taken in EX
//   i_mem_busy         data memory is not ready
//   o_pc_write_en      PC update enable
//   o_ifid_write_en    IF/ID update enable
//   o_ifid_flush       IF/ID loads a NOP
//   o_idex_bubble      zeroes ID/EX on the next edge
//   o_pipe_freeze      holds EX/MEM and MEM/WB
//   o_hazard_state     current FSM state (debug)
//
// Optional feature, macro HAZARD_PERF_EN: adds three saturating 32-bit
// performance counters (o_perf_stall_cnt, o_perf_flush_cnt,
// o_perf_freeze_cnt).

module hazard_ctrl #(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES      = 2,
   parameter int CNT_W             = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] i_id_rs1,
   input  logic [4:0] i_id_rs2,
   input  logic       i_id_uses_rs1,
   input  logic       i_id_uses_rs2,
   input  logic       i_idex_mem_read,
   input  logic [4:0] i_idex_rd,
   input  logic       i_ex_branch_taken,
   input  logic       i_mem_busy,
   output logic       o_pc_write_en,
   output logic       o_ifid_write_en,
   output logic       o_ifid_flush,
   output logic       o_idex_bubble,
   output logic       o_pipe_freeze,
   output logic [1:0] o_hazard_state
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] o_perf_stall_cnt,
   output logic [31:0] o_perf_flush_cnt,
   output logic [31:0] o_perf_freeze_cnt
`endif
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      LSTALL = 2'd1,
      FLUSH  = 2'd2,
      MWAIT  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LSTALL_RELOAD =
      (LOAD_STALL_CYCLES > 1) ? CNT_W'(LOAD_STALL_CYCLES - 2) : '0;
   localparam logic [CNT_W-1:0] FLUSH_RELOAD =
      (FLUSH_CYCLES > 1) ? CNT_W'(FLUSH_CYCLES - 2) : '0;

   state_t           r_state, w_state_nxt;
   state_t           r_saved_state, w_saved_state_nxt;
   state_t           w_eff_state;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [CNT_W-1:0] r_saved_cnt, w_saved_cnt_nxt;
   logic [CNT_W-1:0] w_eff_cnt;
   logic             w_load_use;
   logic             w_pc_we, w_ifid_we, w_flush, w_bubble, w_freeze;

   assign w_load_use = i_idex_mem_read & (i_idex_rd != 5'd0) &
                       ((i_id_uses_rs1 & (i_id_rs1 == i_idex_rd)) |
                        (i_id_uses_rs2 & (i_id_rs2 == i_idex_rd)));

   // On the cycle mem_busy drops, MWAIT behaves exactly like the saved
   // state with the saved count, so one decode serves both cases.
   always_comb begin
      w_eff_state = r_state;
      w_eff_cnt   = r_cnt;
      if (r_state == MWAIT) begin
         w_eff_state = r_saved_state;
         w_eff_cnt   = r_saved_cnt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_cnt_nxt         = r_cnt;
      w_saved_state_nxt = r_saved_state;
      w_saved_cnt_nxt   = r_saved_cnt;
      w_pc_we           = 1'b0;
      w_ifid_we         = 1'b0;
      w_flush           = 1'b0;
      w_bubble          = 1'b0;
      w_freeze          = 1'b0;

      if (i_mem_busy) begin
         w_freeze    = 1'b1;
         w_state_nxt = MWAIT;
         if (r_state != MWAIT) begin
            w_saved_state_nxt = r_state;
            w_saved_cnt_nxt   = r_cnt;
         end
      end else if (i_ex_branch_taken) begin
         w_pc_we   = 1'b1;
         w_ifid_we = 1'b1;
         w_flush   = 1'b1;
         w_bubble  = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            w_state_nxt = FLUSH;
            w_cnt_nxt   = FLUSH_RELOAD;
         end else begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
         end
      end else begin
         case (w_eff_state)
            LSTALL: begin
               w_bubble = 1'b1;
               if (w_eff_cnt == '0) begin
                  w_state_nxt = RUN;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = LSTALL;
                  w_cnt_nxt   = w_eff_cnt - 1'b1;
               end
            end
            FLUSH: begin
               w_pc_we   = 1'b1;
               w_ifid_we = 1'b1;
               w_flush   = 1'b1;
               w_bubble  = 1'b1;
               if (w_eff_cnt == '0) begin
                  w_state_nxt = RUN;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = FLUSH;
                  w_cnt_nxt   = w_eff_cnt - 1'b1;
               end
            end
            default: begin
               w_cnt_nxt = '0;
               if (w_load_use) begin
                  w_bubble = 1'b1;
                  if (LOAD_STALL_CYCLES > 1) begin
                     w_state_nxt = LSTALL;
                     w_cnt_nxt   = LSTALL_RELOAD;
                  end else begin
                     w_state_nxt = RUN;
                  end
               end else begin
                  w_pc_we     = 1'b1;
                  w_ifid_we   = 1'b1;
                  w_state_nxt = RUN;
               end
            end
         endcase
      end

      // While reset is held the pipe loads NOPs and nothing advances.
      if (reset) begin
         w_pc_we   = 1'b0;
         w_ifid_we = 1'b0;
         w_flush   = 1'b1;
         w_bubble  = 1'b1;
         w_freeze  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= RUN;
         r_cnt         <= '0;
         r_saved_state <= RUN;
         r_saved_cnt   <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_saved_state <= w_saved_state_nxt;
         r_saved_cnt   <= w_saved_cnt_nxt;
      end
   end

   assign o_pc_write_en   = w_pc_we;
   assign o_ifid_write_en = w_ifid_we;
   assign o_ifid_flush    = w_flush;
   assign o_idex_bubble   = w_bubble;
   assign o_pipe_freeze   = w_freeze;
   assign o_hazard_state  = r_state;

`ifdef HAZARD_PERF_EN
   logic [31:0] r_perf_stall, r_perf_flush, r_perf_freeze;

   // Counters only advance with reset low, so reset cycles never count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_perf_stall  <= '0;
         r_perf_flush  <= '0;
         r_perf_freeze <= '0;
      end else begin
         if (w_bubble && !w_flush && (r_perf_stall != '1))
            r_perf_stall <= r_perf_stall + 32'd1;
         if (w_flush && (r_perf_flush != '1))
            r_perf_flush <= r_perf_flush + 32'd1;
         if (w_freeze && (r_perf_freeze != '1))
            r_perf_freeze <= r_perf_freeze + 32'd1;
      end
   end

   assign o_perf_stall_cnt  = r_perf_stall;
   assign o_perf_flush_cnt  = r_perf_flush;
   assign o_perf_freeze_cnt = r_perf_freeze;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default-parameter instance and a
// LOAD_STALL_CYCLES = 3 instance share the same stimulus.
// Packed output vector: {pc_we, ifid_we, flush, bubble, freeze, state[1:0]}.

module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs1, id_rs2, idex_rd;
   logic       uses1, uses2, mem_read, br, busy;

   logic       pc0, ifwe0, fl0, bb0, fz0;
   logic [1:0] st0;
   logic       pc3, ifwe3, fl3, bb3, fz3;
   logic [1:0] st3;
   logic [6:0] v0, v3;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

`ifdef HAZARD_PERF_EN
   logic [31:0] ps0, pf0, pz0, ps3, pf3, pz3;
`endif

   hazard_ctrl dut0 (
      .clk               (clk),
      .reset             (reset),
      .i_id_rs1          (id_rs1),
      .i_id_rs2          (id_rs2),
      .i_id_uses_rs1     (uses1),
      .i_id_uses_rs2     (uses2),
      .i_idex_mem_read   (mem_read),
      .i_idex_rd         (idex_rd),
      .i_ex_branch_taken (br),
      .i_mem_busy        (busy),
      .o_pc_write_en     (pc0),
      .o_ifid_write_en   (ifwe0),
      .o_ifid_flush      (fl0),
      .o_idex_bubble     (bb0),
      .o_pipe_freeze     (fz0),
      .o_hazard_state    (st0)
`ifdef HAZARD_PERF_EN
      ,
      .o_perf_stall_cnt  (ps0),
      .o_perf_flush_cnt  (pf0),
      .o_perf_freeze_cnt (pz0)
`endif
   );

   hazard_ctrl #(.LOAD_STALL_CYCLES(3)) dut3 (
      .clk               (clk),
      .reset             (reset),
      .i_id_rs1          (id_rs1),
      .i_id_rs2          (id_rs2),
      .i_id_uses_rs1     (uses1),
      .i_id_uses_rs2     (uses2),
      .i_idex_mem_read   (mem_read),
      .i_idex_rd         (idex_rd),
      .i_ex_branch_taken (br),
      .i_mem_busy        (busy),
      .o_pc_write_en     (pc3),
      .o_ifid_write_en   (ifwe3),
      .o_ifid_flush      (fl3),
      .o_idex_bubble     (bb3),
      .o_pipe_freeze     (fz3),
      .o_hazard_state    (st3)
`ifdef HAZARD_PERF_EN
      ,
      .o_perf_stall_cnt  (ps3),
      .o_perf_flush_cnt  (pf3),
      .o_perf_freeze_cnt (pz3)
`endif
   );

   assign v0 = {pc0, ifwe0, fl0, bb0, fz0, st0};
   assign v3 = {pc3, ifwe3, fl3, bb3, fz3, st3};

   localparam logic [6:0] E_RUN    = 7'b1100000;
   localparam logic [6:0] E_STALL  = 7'b0001000;
   localparam logic [6:0] E_BR     = 7'b1111000;
   localparam logic [6:0] E_FLUSH  = 7'b1111010;
   localparam logic [6:0] E_RESET  = 7'b0011000;

   task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Inputs change right after a falling edge; the Mealy outputs are
   // sampled 1 time unit later, well away from the rising edge.
   task automatic drv(input logic b, input logic t, input logic mr, input logic [4:0] rd,
                      input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
      @(negedge clk);
      busy = b; br = t; mem_read = mr; idex_rd = rd;
      id_rs1 = r1; uses1 = u1; id_rs2 = r2; uses2 = u2;
      #1;
   endtask

   task automatic idle();
      drv(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      busy = 1'b0; br = 1'b0; mem_read = 1'b0; idex_rd = 5'd0;
      id_rs1 = 5'd0; uses1 = 1'b0; id_rs2 = 5'd0; uses2 = 1'b0;

      // Reset values
      idle();
      chk("reset_d0", v0, E_RESET);
      chk("reset_d3", v3, E_RESET);
      reset = 1'b0;
      idle();
      chk("run_idle", v0, E_RUN);

      // Load-use on rs1, one bubble cycle then RUN
      drv(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      chk("lu_rs1", v0, E_STALL);
      idle();
      chk("lu_rs1_after", v0, E_RUN);

      // x0 destination and unused source never stall
      drv(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
      chk("lu_x0", v0, E_RUN);
      drv(1'b0, 1'b0, 1'b1, 5'd7, 5'd0, 1'b0, 5'd7, 1'b0);
      chk("lu_rs2_unused", v0, E_RUN);
      drv(1'b0, 1'b0, 1'b1, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1);
      chk("lu_rs2", v0, E_STALL);
      idle();
      chk("lu_rs2_after", v0, E_RUN);

      // Taken branch: two flush cycles, state 0 -> 2 -> 0
      drv(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      chk("br_c1", v0, E_BR);
      idle();
      chk("br_c2", v0, E_FLUSH);
      idle();
      chk("br_done", v0, E_RUN);

      // Branch beats load-use
      drv(1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      chk("prio_br_lu", v0, E_BR);
      idle();
      chk("prio_br_lu_c2", v0, E_FLUSH);
      idle();
      chk("prio_br_lu_done", v0, E_RUN);

      // Freeze beats branch and load-use
      drv(1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      chk("prio_busy", v0, 7'b0000100);
      idle();
      chk("mwait_resume_run", v0, 7'b1100011);
      idle();
      chk("after_resume_run", v0, E_RUN);

      // Freeze in the middle of a flush
      drv(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      chk("mf_branch", v0, E_BR);
      drv(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      chk("mf_freeze1", v0, 7'b0000110);
      drv(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      chk("mf_freeze2", v0, 7'b0000111);
      drv(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      chk("mf_freeze3", v0, 7'b0000111);
      idle();
      chk("mf_resume_flush", v0, 7'b1111011);
      idle();
      chk("mf_run", v0, E_RUN);

      // New branch during FLUSH reloads the counter
      drv(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      chk("rl_br1", v0, E_BR);
      drv(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      chk("rl_br2", v0, E_FLUSH);
      idle();
      chk("rl_last", v0, E_FLUSH);
      idle();
      chk("rl_run", v0, E_RUN);

      // LOAD_STALL_CYCLES = 3 instance: clean start
      reset = 1'b1;
      idle();
      chk("d3_reset", v3, E_RESET);
      reset = 1'b0;
      idle();
      chk("d3_run", v3, E_RUN);

      // Branch preempts LSTALL
      drv(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      chk("d3_lu", v3, E_STALL);
      drv(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      chk("d3_lstall_br", v3, 7'b1111001);
      idle();
      chk("d3_flush", v3, E_FLUSH);
      idle();
      chk("d3_run2", v3, E_RUN);

      // Reset at stall cycle 2
      drv(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      chk("d3_stall1", v3, E_STALL);
      idle();
      chk("d3_stall2", v3, 7'b0001001);
      reset = 1'b1;
      #1;
      chk("d3_async_reset", v3, E_RESET);
      idle();
      chk("d3_reset_held", v3, E_RESET);
      reset = 1'b0;
      idle();
      chk("d3_after_reset", v3, E_RUN);
`ifdef HAZARD_PERF_EN
      chk32("perf_stall_zero", ps3, 32'd0);
      chk32("perf_flush_zero", pf3, 32'd0);
      chk32("perf_freeze_zero", pz3, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
